// File: rtl/mult_fu_if.sv
// mult_fu_pkg / mult_fu_if
// Shared widths, func encodings and the issue packet type, plus the bundle of
// issue, backpressure, flush and CDB signals between the multiply unit and its
// surroundings.
//   master : reservation station / CDB arbiter side (drives packet, grant, squash)
//   slave  : multiply unit side (drives avail and the CDB request/result)
package mult_fu_pkg;
    localparam int PRN_WIDTH     = 6;
    localparam int ROB_CNT_WIDTH = 5;

    localparam logic [2:0] FUNC_MUL    = 3'd0;
    localparam logic [2:0] FUNC_MULH   = 3'd1;
    localparam logic [2:0] FUNC_MULHSU = 3'd2;
    localparam logic [2:0] FUNC_MULHU  = 3'd3;

    typedef struct packed {
        logic                     valid;
        logic [2:0]               func;
        logic [31:0]              op1;
        logic [31:0]              op2;
        logic [PRN_WIDTH-1:0]     dest_prn;
        logic [ROB_CNT_WIDTH-1:0] robn;
    } fu_packet_t;
endpackage

interface mult_fu_if;
    import mult_fu_pkg::*;

    fu_packet_t               fu_packet;
    logic                     cdb_gnt;
    logic                     squash;
    logic                     avail;
    logic                     cdb_req;
    logic [31:0]              cdb_value;
    logic [PRN_WIDTH-1:0]     cdb_dest_prn;
    logic [ROB_CNT_WIDTH-1:0] cdb_robn;

    modport master (
        output fu_packet, cdb_gnt, squash,
        input  avail, cdb_req, cdb_value, cdb_dest_prn, cdb_robn
    );

    modport slave (
        input  fu_packet, cdb_gnt, squash,
        output avail, cdb_req, cdb_value, cdb_dest_prn, cdb_robn
    );
endinterface

// File: rtl/mult_fu.sv
// mult_fu
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU). STAGES registers deep
// including the output register; results wait in OUT until the CDB grants them.
// A one-entry skid register absorbs the packet that arrives in a stall cycle.
// Ports:
//   clock  system clock
//   reset  asynchronous active-low reset
//   bus    mult_fu_if.slave: fu_packet, cdb_gnt, squash in; avail, cdb_* out
module mult_fu
    import mult_fu_pkg::*;
#(
    parameter int STAGES = 4
) (
    input  logic        clock,
    input  logic        reset,
    mult_fu_if.slave    bus
);

    // Operands are held 33 bits wide, pre-extended according to func, so a
    // single product covers all four signedness combinations.
    typedef struct packed {
        logic                     valid;
        logic [2:0]               func;
        logic [32:0]              a;
        logic [32:0]              b;
        logic [63:0]              prod;
        logic [PRN_WIDTH-1:0]     dest_prn;
        logic [ROB_CNT_WIDTH-1:0] robn;
    } stage_t;

    typedef struct packed {
        logic                     valid;
        logic [31:0]              value;
        logic [PRN_WIDTH-1:0]     dest_prn;
        logic [ROB_CNT_WIDTH-1:0] robn;
    } out_t;

    stage_t     stg_q [1:STAGES-1];
    stage_t     stg_d [1:STAGES-1];
    fu_packet_t sk_q, sk_d;
    out_t       out_q, out_d;

    logic        advance;
    logic        stall;
    logic [65:0] full_prod;
    logic [63:0] prod_s1;
    logic [63:0] prod_last;
    stage_t      last;

    function automatic stage_t load_s1(input fu_packet_t p);
        stage_t s;
        logic   sgn_a;
        logic   sgn_b;
        sgn_a      = (p.func != FUNC_MULHU);
        sgn_b      = (p.func == FUNC_MUL) || (p.func == FUNC_MULH);
        s.valid    = p.valid;
        s.func     = p.func;
        s.a        = {sgn_a & p.op1[31], p.op1};
        s.b        = {sgn_b & p.op2[31], p.op2};
        s.prod     = '0;
        s.dest_prn = p.dest_prn;
        s.robn     = p.robn;
        return s;
    endfunction

    assign advance   = ~out_q.valid | bus.cdb_gnt;
    assign stall     = ~advance;
    assign bus.avail = ~sk_q.valid & ~(stall & bus.fu_packet.valid);

    // 66-bit product of the sign-extended 33-bit operands; the low 64 bits
    // are exact for every signedness combination.
    assign full_prod = {{33{stg_q[1].a[32]}}, stg_q[1].a} * {{33{stg_q[1].b[32]}}, stg_q[1].b};
    assign prod_s1   = full_prod[63:0];
    assign last      = stg_q[STAGES-1];
    assign prod_last = (STAGES == 2) ? prod_s1 : last.prod;

    always_comb begin
        stg_d = stg_q;
        sk_d  = sk_q;
        out_d = out_q;

        if (advance) begin
            if (sk_q.valid) begin
                stg_d[1]   = load_s1(sk_q);
                sk_d.valid = 1'b0;
            end else begin
                stg_d[1] = load_s1(bus.fu_packet);
            end

            for (int k = 2; k < STAGES; k++) begin
                stg_d[k] = stg_q[k-1];
                if (k == 2) begin
                    stg_d[k].prod = prod_s1;
                end
            end

            out_d.valid    = last.valid;
            out_d.dest_prn = last.dest_prn;
            out_d.robn     = last.robn;
            case (last.func)
                FUNC_MUL:                            out_d.value = prod_last[31:0];
                FUNC_MULH, FUNC_MULHSU, FUNC_MULHU:  out_d.value = prod_last[63:32];
                default:                             out_d.value = '0;
            endcase
        end else if (bus.fu_packet.valid) begin
            sk_d = bus.fu_packet;
        end

        // Flush wins over grant and advance; data may move but nothing stays valid.
        if (bus.squash) begin
            for (int k = 1; k < STAGES; k++) begin
                stg_d[k].valid = 1'b0;
            end
            sk_d.valid  = 1'b0;
            out_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k < STAGES; k++) begin
                stg_q[k] <= '0;
            end
            sk_q  <= '0;
            out_q <= '0;
        end else begin
            stg_q <= stg_d;
            sk_q  <= sk_d;
            out_q <= out_d;
        end
    end

    assign bus.cdb_req      = out_q.valid;
    assign bus.cdb_value    = out_q.value;
    assign bus.cdb_dest_prn = out_q.dest_prn;
    assign bus.cdb_robn     = out_q.robn;

    // The RS never issues while the skid entry is occupied.
    a_no_issue_into_full_skid : assert property (
        @(posedge clock) disable iff (!reset) !(bus.fu_packet.valid && sk_q.valid)
    );

endmodule

// File: tb/tb_mult_fu.sv
// tb_mult_fu
// Self-checking bench for mult_fu (STAGES=4) using a scoreboard queue of
// expected CDB results pushed at issue and popped on grant.
module tb_mult_fu;
    import mult_fu_pkg::*;

    localparam int STAGES = 4;

    typedef struct {
        logic [31:0]              value;
        logic [PRN_WIDTH-1:0]     prn;
        logic [ROB_CNT_WIDTH-1:0] rob;
    } exp_t;

    logic clock;
    logic reset;
    mult_fu_if bus();

    mult_fu #(.STAGES(STAGES)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic avail_seen;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, ux, sy, uy, p;
        sx = {{32{x[31]}}, x};
        ux = {32'b0, x};
        sy = {{32{y[31]}}, y};
        uy = {32'b0, y};
        case (f)
            FUNC_MUL:    begin p = sx * sy; return p[31:0];  end
            FUNC_MULH:   begin p = sx * sy; return p[63:32]; end
            FUNC_MULHSU: begin p = sx * uy; return p[63:32]; end
            FUNC_MULHU:  begin p = ux * uy; return p[63:32]; end
            default:     return 32'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input int prn, input int rob, input logic [31:0] expv);
        exp_t e;
        bus.fu_packet.valid    = 1'b1;
        bus.fu_packet.func     = f;
        bus.fu_packet.op1      = x;
        bus.fu_packet.op2      = y;
        bus.fu_packet.dest_prn = PRN_WIDTH'(prn);
        bus.fu_packet.robn     = ROB_CNT_WIDTH'(rob);
        e.value = expv;
        e.prn   = PRN_WIDTH'(prn);
        e.rob   = ROB_CNT_WIDTH'(rob);
        exp_q.push_back(e);
    endtask

    task automatic send_rand();
        logic [2:0]  f;
        logic [31:0] x, y;
        f = 3'($urandom_range(0, 4));
        if (f == 3'd4) f = 3'd7;
        x = $urandom();
        y = $urandom();
        send(f, x, y, $urandom_range(0, 63), $urandom_range(0, 31), model(f, x, y));
    endtask

    task automatic idle();
        bus.fu_packet.valid = 1'b0;
    endtask

    // Advance until cdb_req is seen at a negedge; n = cycles waited.
    task automatic wait_req(output int n);
        n = 0;
        do begin
            tick();
            idle();
            n++;
            @(negedge clock);
        end while (!bus.cdb_req && n < 20);
    endtask

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.fu_packet.valid && bus.cdb_req && !bus.cdb_gnt)
                chk("avail_drop", 64'(bus.avail), 64'd0);
            if (bus.cdb_req) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_req", 64'(bus.cdb_req), 64'd0);
                end else begin
                    chk("cdb_value", 64'(bus.cdb_value), 64'(exp_q[0].value));
                    chk("cdb_prn",   64'(bus.cdb_dest_prn), 64'(exp_q[0].prn));
                    chk("cdb_rob",   64'(bus.cdb_robn), 64'(exp_q[0].rob));
                end
            end
            if (bus.squash) exp_q.delete();
            else if (bus.cdb_req && bus.cdb_gnt && exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        int n;
        int cnt;
        int idx;

        reset     = 1'b0;
        bus.fu_packet = '0;
        bus.cdb_gnt   = 1'b0;
        bus.squash    = 1'b0;
        #12;
        chk("rst_req",   64'(bus.cdb_req), 64'd0);
        chk("rst_avail", 64'(bus.avail), 64'd1);
        chk("rst_value", 64'(bus.cdb_value), 64'd0);
        chk("rst_prn",   64'(bus.cdb_dest_prn), 64'd0);
        chk("rst_rob",   64'(bus.cdb_robn), 64'd0);
        tick();

        // Single MUL in the first cycle after reset release.
        reset = 1'b1;
        bus.cdb_gnt = 1'b1;
        send(FUNC_MUL, 32'd7, 32'd6, 5, 3, 32'd42);
        @(negedge clock);
        wait_req(n);
        chk("mul_latency", 64'(n), 64'(STAGES));
        tick();
        @(negedge clock);
        chk("mul_req_after", 64'(bus.cdb_req), 64'd0);
        repeat (3) tick();

        // Four back-to-back packets, results in consecutive cycles.
        send(FUNC_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'h00000000); tick();
        send(FUNC_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 2, 2, 32'hFFFFFFFE); tick();
        send(FUNC_MULHSU, 32'hFFFFFFFF, 32'h00000002, 3, 3, 32'hFFFFFFFF); tick();
        send(FUNC_MUL,    32'h80000000, 32'hFFFFFFFF, 4, 4, 32'h80000000); tick();
        idle();
        cnt = 0;
        for (int c = 4; c < 8; c++) begin
            @(negedge clock);
            if (bus.cdb_req) cnt++;
            tick();
        end
        chk("b2b_req_count", 64'(cnt), 64'd4);
        chk("b2b_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) tick();

        // Backpressure with issue gated by avail.
        avail_seen = 1'b1;
        idx = 0;
        for (int c = 0; c < 80; c++) begin
            bus.cdb_gnt = (c < 4) || (c >= 14);
            if (avail_seen && idx < 10) begin
                send_rand();
                idx++;
            end else begin
                idle();
            end
            @(negedge clock);
            avail_seen = bus.avail;
            tick();
            if (idx == 10 && exp_q.size() == 0) break;
        end
        idle();
        chk("bp_issued", 64'(idx), 64'd10);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) tick();

        // Squash with three in flight, one in the skid register.
        bus.cdb_gnt = 1'b0;
        send(FUNC_MUL, 32'd11, 32'd2, 10, 10, 32'd22); tick();
        idle(); tick();
        send(FUNC_MUL, 32'd12, 32'd2, 11, 11, 32'd24); tick();
        idle(); tick();
        send(FUNC_MUL, 32'd13, 32'd2, 12, 12, 32'd26);
        @(negedge clock);
        chk("stall_avail", 64'(bus.avail), 64'd0);
        tick();
        idle();
        bus.squash = 1'b1;
        @(negedge clock);
        chk("skid_avail", 64'(bus.avail), 64'd0);
        tick();
        bus.squash  = 1'b0;
        bus.cdb_gnt = 1'b1;
        send(FUNC_MUL, 32'd3, 32'd3, 7, 7, 32'd9);
        @(negedge clock);
        chk("sq_req", 64'(bus.cdb_req), 64'd0);
        chk("sq_avail", 64'(bus.avail), 64'd1);
        wait_req(n);
        chk("sq_latency", 64'(n), 64'(STAGES));
        repeat (3) tick();

        // Squash in the same cycle as a grant with OUT valid.
        send(FUNC_MUL, 32'd5, 32'd5, 20, 20, 32'd25); tick();
        send(FUNC_MUL, 32'd6, 32'd5, 21, 21, 32'd30); tick();
        idle(); tick();
        tick();
        bus.squash = 1'b1;
        @(negedge clock);
        chk("sqgnt_req", 64'(bus.cdb_req), 64'd1);
        tick();
        bus.squash = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clock);
            if (bus.cdb_req) cnt++;
            tick();
        end
        chk("sqgnt_stale", 64'(cnt), 64'd0);

        // Asynchronous reset with the pipeline full.
        bus.cdb_gnt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            send(FUNC_MULHU, 32'(c + 100), 32'hFFFF0000, 30 + c, 20 + c,
                 model(FUNC_MULHU, 32'(c + 100), 32'hFFFF0000));
            tick();
        end
        idle(); tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req",   64'(bus.cdb_req), 64'd0);
        chk("arst_avail", 64'(bus.avail), 64'd1);
        chk("arst_value", 64'(bus.cdb_value), 64'd0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        bus.cdb_gnt = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus.cdb_req) cnt++;
            tick();
        end
        chk("arst_no_result", 64'(cnt), 64'd0);

        // Random traffic with random grants.
        avail_seen = 1'b1;
        for (int c = 0; c < 60; c++) begin
            bus.cdb_gnt = ($urandom_range(0, 3) != 0);
            if (avail_seen && $urandom_range(0, 9) < 7) send_rand();
            else idle();
            @(negedge clock);
            avail_seen = bus.avail;
            tick();
        end
        idle();
        bus.cdb_gnt = 1'b1;
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) tick();
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
